tlm_fifo: RTL and testbench



---
 rtl/tlm_fifo_pkg.sv | 13 +
 rtl/tlm_fifo_if.sv | 26 ++
 rtl/tlm_fifo_mem.sv | 26 ++
 rtl/tlm_fifo.sv | 83 ++++++++
 tb/tb_tlm_fifo.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlm_fifo_pkg.sv
// Shared types and helpers for the tlm_fifo channel.
// Sizing helper keeps pointer/count widths >= 1 for tiny depths.
package tlm_fifo_pkg;

  localparam int DEFAULT_DATA_W = 65;

  typedef enum logic [1:0] {PUT_ONLY, GET_ONLY, BOTH, IDLE} fifo_op_e;

  function automatic int clog2_depth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tlm_fifo_if.sv
// Put/get valid-ready channel bundle for tlm_fifo.
// slave is the FIFO side, master is the producer/consumer side.
interface tlm_fifo_if
  import tlm_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              put_valid;
  logic              put_ready;
  logic [DATA_W-1:0] put_data;
  logic              get_valid;
  logic              get_ready;
  logic [DATA_W-1:0] get_data;

  modport slave (
    input  put_valid, put_data, get_ready,
    output put_ready, get_valid, get_data
  );

  modport master (
    output put_valid, put_data, get_ready,
    input  put_ready, get_valid, get_data
  );

endinterface

// File: rtl/tlm_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module tlm_fifo_mem
  import tlm_fifo_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = clog2_depth(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tlm_fifo.sv
// First-word fall-through FIFO with valid/ready on both sides.
// Define TLM_FIFO_LEVEL_EN to expose level and almost_full ports.
module tlm_fifo
  import tlm_fifo_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = clog2_depth(DEPTH),
  localparam int CNT_W  = clog2_depth(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  tlm_fifo_if.slave        fifo
`ifdef TLM_FIFO_LEVEL_EN
  ,
  output logic [CNT_W-1:0] level,
  output logic             almost_full
`endif
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              put_fire;
  logic              get_fire;
  logic [DATA_W-1:0] rd_data;
  fifo_op_e          op;

  // Ready/valid come from count alone, so a full FIFO refuses a put even while a get fires.
  assign fifo.put_ready = (count != FULL_CNT);
  assign fifo.get_valid = (count != '0);
  assign fifo.get_data  = fifo.get_valid ? rd_data : '0;

  assign put_fire = fifo.put_valid && fifo.put_ready;
  assign get_fire = fifo.get_valid && fifo.get_ready;

  always_comb begin
    op = IDLE;
    case ({put_fire, get_fire})
      2'b10:   op = PUT_ONLY;
      2'b01:   op = GET_ONLY;
      2'b11:   op = BOTH;
      default: op = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (put_fire) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (get_fire) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case (op)
        PUT_ONLY: count <= count + 1'b1;
        GET_ONLY: count <= count - 1'b1;
        default:  count <= count;
      endcase
    end
  end

  tlm_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (put_fire),
    .wr_addr (wr_ptr),
    .wr_data (fifo.put_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

`ifdef TLM_FIFO_LEVEL_EN
  assign level       = count;
  assign almost_full = (count >= CNT_W'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_tlm_fifo.sv
// Scoreboard bench for tlm_fifo: DEPTH=4 and DEPTH=3 instances sharing clock and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_tlm_fifo;
  import tlm_fifo_pkg::*;

  localparam int W = DEFAULT_DATA_W;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [W-1:0] q4[$];
  logic [W-1:0] q3[$];

  always #5 clk = ~clk;

  tlm_fifo_if #(.DATA_W(W)) if4 ();
  tlm_fifo_if #(.DATA_W(W)) if3 ();

`ifdef TLM_FIFO_LEVEL_EN
  logic [2:0] level4;
  logic       af4;
  logic [1:0] level3;
  logic       af3;
`endif

  tlm_fifo #(.DATA_W(W), .DEPTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .fifo  (if4)
`ifdef TLM_FIFO_LEVEL_EN
    , .level (level4), .almost_full (af4)
`endif
  );

  tlm_fifo #(.DATA_W(W), .DEPTH(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .fifo  (if3)
`ifdef TLM_FIFO_LEVEL_EN
    , .level (level3), .almost_full (af3)
`endif
  );

  task automatic cyc4(input logic pv, input logic [W-1:0] pd, input logic gr,
                      output logic pr, output logic gv, output logic [W-1:0] gd);
    @(negedge clk);
    if4.put_valid = pv;
    if4.put_data  = pd;
    if4.get_ready = gr;
    pr = if4.put_ready;
    gv = if4.get_valid;
    gd = if4.get_data;
  endtask

  task automatic cyc3(input logic pv, input logic [W-1:0] pd, input logic gr,
                      output logic pr, output logic gv, output logic [W-1:0] gd);
    @(negedge clk);
    if3.put_valid = pv;
    if3.put_data  = pd;
    if3.get_ready = gr;
    pr = if3.put_ready;
    gv = if3.get_valid;
    gd = if3.get_data;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (if4.put_ready !== 1'b1) begin failures++; $display("FAIL reset_put_ready got=%b exp=1", if4.put_ready); end
    checks++; if (if4.get_valid !== 1'b0) begin failures++; $display("FAIL reset_get_valid got=%b exp=0", if4.get_valid); end
    checks++; if (if4.get_data !== '0) begin failures++; $display("FAIL reset_get_data got=%h exp=0", if4.get_data); end
    checks++; if (if3.put_ready !== 1'b1 || if3.get_valid !== 1'b0) begin failures++; $display("FAIL reset_d3 got=%b%b exp=10", if3.put_ready, if3.get_valid); end
`ifdef TLM_FIFO_LEVEL_EN
    checks++; if (level4 !== 3'd0 || af4 !== 1'b0) begin failures++; $display("FAIL reset_level got=%0d/%b exp=0/0", level4, af4); end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic pr, gv;
    logic [W-1:0] gd, exp;
    for (int i = 0; i < 5; i++) begin
      logic pv, gr;
      pv = (i == 2);
      gr = (i == 3);
      cyc4(pv, 65'h1_0000_0000_0000_00AB, gr, pr, gv, gd);
      checks++; if (gv !== (q4.size() != 0)) begin failures++; $display("FAIL single_get_valid cyc=%0d got=%b exp=%b", i, gv, q4.size() != 0); end
      if (gv && gr) begin
        exp = q4.pop_front();
        checks++; if (gd !== exp) begin failures++; $display("FAIL single_data got=%h exp=%h", gd, exp); end
      end
      if (pv && pr) q4.push_back(65'h1_0000_0000_0000_00AB);
    end
  endtask

  task automatic test_fill();
    logic pr, gv;
    logic [W-1:0] gd, exp, pd;
    for (int i = 0; i < 7; i++) begin
      pd = (i < 4) ? W'(i + 1) : W'(5);
      cyc4(1'b1, pd, 1'b0, pr, gv, gd);
      checks++; if (pr !== (q4.size() != 4)) begin failures++; $display("FAIL fill_put_ready cyc=%0d got=%b exp=%b", i, pr, q4.size() != 4); end
`ifdef TLM_FIFO_LEVEL_EN
      checks++; if (af4 !== (q4.size() >= 3) || level4 !== 3'(q4.size())) begin failures++; $display("FAIL fill_level cyc=%0d got=%0d/%b exp=%0d/%b", i, level4, af4, q4.size(), q4.size() >= 3); end
`endif
      if (pr) q4.push_back(pd);
    end
    for (int i = 0; i < 5; i++) begin
      cyc4(1'b0, '0, 1'b1, pr, gv, gd);
      checks++; if (gv !== (q4.size() != 0)) begin failures++; $display("FAIL fill_get_valid cyc=%0d got=%b exp=%b", i, gv, q4.size() != 0); end
      if (gv) begin
        exp = q4.pop_front();
        checks++; if (gd !== exp) begin failures++; $display("FAIL fill_order got=%h exp=%h", gd, exp); end
      end
    end
  endtask

  task automatic test_stream();
    logic pr, gv;
    logic [W-1:0] gd, exp;
    int nout = 0;
    for (int i = 0; i < 20; i++) begin
      cyc4(1'b1, W'(i), 1'b1, pr, gv, gd);
      checks++; if (pr !== 1'b1) begin failures++; $display("FAIL stream_put_ready cyc=%0d got=%b exp=1", i, pr); end
`ifdef TLM_FIFO_LEVEL_EN
      checks++; if (level4 !== 3'(q4.size())) begin failures++; $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", i, level4, q4.size()); end
`endif
      if (gv) begin
        exp = q4.pop_front();
        nout++;
        checks++; if (gd !== exp) begin failures++; $display("FAIL stream_order got=%h exp=%h", gd, exp); end
      end
      if (pr) q4.push_back(W'(i));
    end
    checks++; if (nout !== 19) begin failures++; $display("FAIL stream_count got=%0d exp=19", nout); end
    cyc4(1'b0, '0, 1'b1, pr, gv, gd);
    checks++; if (!gv || q4.size() == 0) begin failures++; $display("FAIL stream_tail got_valid=%b exp=1", gv); end
    else begin
      exp = q4.pop_front();
      checks++; if (gd !== exp) begin failures++; $display("FAIL stream_tail_data got=%h exp=%h", gd, exp); end
    end
  endtask

  task automatic test_full_get();
    logic pr, gv;
    logic [W-1:0] gd, exp;
    for (int i = 0; i < 4; i++) begin
      cyc4(1'b1, W'('h40 + i), 1'b0, pr, gv, gd);
      if (pr) q4.push_back(W'('h40 + i));
    end
    cyc4(1'b1, W'('h50), 1'b1, pr, gv, gd);
    checks++; if (pr !== 1'b0) begin failures++; $display("FAIL full_get_put_refused got=%b exp=0", pr); end
    checks++; if (gv !== 1'b1) begin failures++; $display("FAIL full_get_valid got=%b exp=1", gv); end
    if (gv) begin
      exp = q4.pop_front();
      checks++; if (gd !== exp) begin failures++; $display("FAIL full_get_data got=%h exp=%h", gd, exp); end
    end
    if (pr) q4.push_back(W'('h50));
    cyc4(1'b1, W'('h50), 1'b0, pr, gv, gd);
    checks++; if (pr !== 1'b1) begin failures++; $display("FAIL full_get_next_put got=%b exp=1", pr); end
    if (pr) q4.push_back(W'('h50));
    cyc4(1'b0, '0, 1'b0, pr, gv, gd);
    checks++; if (pr !== (q4.size() != 4)) begin failures++; $display("FAIL full_get_refill got=%b exp=%b", pr, q4.size() != 4); end
`ifdef TLM_FIFO_LEVEL_EN
    checks++; if (level4 !== 3'd4) begin failures++; $display("FAIL full_get_level got=%0d exp=4", level4); end
`endif
    for (int i = 0; i < 5; i++) begin
      cyc4(1'b0, '0, 1'b1, pr, gv, gd);
      checks++; if (gv !== (q4.size() != 0)) begin failures++; $display("FAIL full_drain_valid cyc=%0d got=%b exp=%b", i, gv, q4.size() != 0); end
      if (gv && q4.size() != 0) begin
        exp = q4.pop_front();
        checks++; if (gd !== exp) begin failures++; $display("FAIL full_drain_order got=%h exp=%h", gd, exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic pr, gv;
    logic [W-1:0] gd, exp;
    for (int i = 0; i < 2; i++) begin
      cyc4(1'b1, W'('h60 + i), 1'b0, pr, gv, gd);
      if (pr) q4.push_back(W'('h60 + i));
    end
    @(negedge clk);
    if4.put_valid = 1'b0;
    if4.get_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (if4.put_ready !== 1'b1 || if4.get_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_hs got=%b%b exp=10", if4.put_ready, if4.get_valid); end
    checks++; if (if4.get_data !== '0) begin failures++; $display("FAIL mid_reset_data got=%h exp=0", if4.get_data); end
`ifdef TLM_FIFO_LEVEL_EN
    checks++; if (level4 !== 3'd0 || af4 !== 1'b0) begin failures++; $display("FAIL mid_reset_level got=%0d/%b exp=0/0", level4, af4); end
`endif
    q4.delete();
    q3.delete();
    @(negedge clk);
    reset = 1'b1;
    cyc4(1'b1, W'('h77), 1'b0, pr, gv, gd);
    checks++; if (gv !== 1'b0) begin failures++; $display("FAIL mid_reset_discard got=%b exp=0", gv); end
    if (pr) q4.push_back(W'('h77));
    cyc4(1'b0, '0, 1'b1, pr, gv, gd);
    checks++; if (gv !== 1'b1) begin failures++; $display("FAIL mid_reset_fresh_valid got=%b exp=1", gv); end
    if (gv && q4.size() != 0) begin
      exp = q4.pop_front();
      checks++; if (gd !== exp) begin failures++; $display("FAIL mid_reset_fresh_data got=%h exp=%h", gd, exp); end
    end
    cyc4(1'b0, '0, 1'b0, pr, gv, gd);
  endtask

  task automatic test_depth3();
    logic pr, gv, gr, pending;
    logic [W-1:0] gd, exp, pd;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    pending = 1'b0;
    pd      = '0;
    while (got < 10 && cyc < 400) begin
      if (!pending && sent < 10 && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        pd = {1'($urandom), 32'($urandom), 32'($urandom)};
      end
      gr = ($urandom_range(0, 2) != 0);
      cyc3(pending, pd, gr, pr, gv, gd);
      checks++; if (pr !== (q3.size() != 3)) begin failures++; $display("FAIL d3_put_ready cyc=%0d got=%b exp=%b", cyc, pr, q3.size() != 3); end
      checks++; if (gv !== (q3.size() != 0)) begin failures++; $display("FAIL d3_get_valid cyc=%0d got=%b exp=%b", cyc, gv, q3.size() != 0); end
      if (gv && gr && q3.size() != 0) begin
        exp = q3.pop_front();
        got++;
        checks++; if (gd !== exp) begin failures++; $display("FAIL d3_order n=%0d got=%h exp=%h", got, gd, exp); end
      end
      if (pending && pr) begin
        q3.push_back(pd);
        pending = 1'b0;
        sent++;
      end
      cyc++;
    end
    checks++; if (got !== 10) begin failures++; $display("FAIL d3_timeout got=%0d exp=10", got); end
    cyc3(1'b0, '0, 1'b0, pr, gv, gd);
  endtask

  initial begin
    reset         = 1'b0;
    if4.put_valid = 1'b0;
    if4.put_data  = '0;
    if4.get_ready = 1'b0;
    if3.put_valid = 1'b0;
    if3.put_data  = '0;
    if3.get_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_full_get();
    test_reset_mid();
    test_depth3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
